// File: rtl/mario_motion.sv
// Per-frame motion controller for the Mario sprite: walking, jumping, falling,
// ladder climbing and the death/respawn sequence, with outputs registered.
module mario_motion #(
  parameter int WALK_STEP  = 2,
  parameter int CLIMB_STEP = 2,
  parameter int JUMP_V     = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 8,
  parameter int DIE_TICKS  = 60,
  parameter int START_X    = 80,
  parameter int START_Y    = 390
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_jump,
  input  logic       on_floor,
  input  logic       on_ladder,
  input  logic       hit,
  output logic [9:0] posX,
  output logic [8:0] posY,
  output logic [2:0] state,
  output logic       respawn
);

  localparam int MIN_X = 80;
  localparam int MAX_X = 560;
  localparam int MIN_Y = 90;
  localparam int MAX_Y = 390;
  localparam int CNT_W = $clog2(DIE_TICKS + 1);

  localparam logic signed [5:0] JUMP_VY  = 6'(-JUMP_V);
  localparam logic signed [5:0] GRAV_VY  = 6'(GRAVITY);
  localparam logic signed [5:0] FALL_MAX = 6'(MAX_FALL);

  typedef enum logic [2:0] {
    ST_INITIAL  = 3'b000,
    ST_FLYING   = 3'b001,
    ST_JUMPING  = 3'b010,
    ST_WALKING  = 3'b011,
    ST_STANDING = 3'b100,
    ST_DYING    = 3'b101,
    ST_CLAMPING = 3'b110
  } state_t;

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic signed [5:0] vy_q, vy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              respawn_q, respawn_d;
  logic              armed;

  function automatic logic [9:0] clamp_x(input logic signed [10:0] v);
    if (v < 11'(MIN_X))      clamp_x = 10'(MIN_X);
    else if (v > 11'(MAX_X)) clamp_x = 10'(MAX_X);
    else                     clamp_x = v[9:0];
  endfunction

  function automatic logic [8:0] clamp_y(input logic signed [9:0] v);
    if (v < 10'(MIN_Y))      clamp_y = 9'(MIN_Y);
    else if (v > 10'(MAX_Y)) clamp_y = 9'(MAX_Y);
    else                     clamp_y = v[8:0];
  endfunction

  // Shared datapath: candidate positions and velocities for every state.
  logic                one_dir;
  logic signed [10:0]  x_base, x_sum;
  logic signed [9:0]   y_base, y_fall, y_climb;
  logic signed [5:0]   vy_grav, vy_fly;
  logic [9:0]          x_steer;

  assign one_dir = btn_left ^ btn_right;
  assign x_base  = $signed({1'b0, x_q});
  assign x_sum   = btn_right ? x_base + 11'(WALK_STEP) : x_base - 11'(WALK_STEP);
  assign x_steer = clamp_x(x_sum);
  assign y_base  = $signed({1'b0, y_q});
  assign y_fall  = y_base + 10'(vy_q);
  assign y_climb = btn_up ? y_base - 10'(CLIMB_STEP) : y_base + 10'(CLIMB_STEP);
  assign vy_grav = vy_q + GRAV_VY;
  assign vy_fly  = (vy_grav > FALL_MAX) ? FALL_MAX : vy_grav;

  // The first edge after reset release only arms the block, so a tick there is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) armed <= 1'b0;
    else     armed <= 1'b1;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    vy_d      = vy_q;
    cnt_d     = cnt_q;
    respawn_d = 1'b0;

    if (tick && armed) begin
      if (hit && state_q != ST_INITIAL && state_q != ST_DYING) begin
        state_d = ST_DYING;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          ST_INITIAL: state_d = ST_STANDING;

          ST_STANDING, ST_WALKING: begin
            if (btn_jump && on_floor) begin
              state_d = ST_JUMPING;
              vy_d    = JUMP_VY;
            end else if (state_q == ST_STANDING && btn_up && on_ladder) begin
              state_d = ST_CLAMPING;
            end else if (!on_floor) begin
              state_d = ST_FLYING;
              vy_d    = '0;
            end else if (one_dir) begin
              state_d = ST_WALKING;
              x_d     = x_steer;
            end else begin
              state_d = ST_STANDING;
            end
          end

          ST_JUMPING: begin
            y_d = clamp_y(y_fall);
            if (one_dir) x_d = x_steer;
            if (y_fall <= 10'(MIN_Y)) begin
              vy_d    = '0;
              state_d = ST_FLYING;
            end else begin
              vy_d = vy_grav;
              if (!vy_grav[5]) state_d = ST_FLYING;
            end
          end

          ST_FLYING: begin
            y_d  = clamp_y(y_fall);
            vy_d = vy_fly;
            if (one_dir) x_d = x_steer;
            // Landing uses the velocity that carried us this tick, not the updated one.
            if ((on_floor && vy_q > 6'sd0) || y_fall >= 10'(MAX_Y)) begin
              state_d = ST_STANDING;
              vy_d    = '0;
            end
          end

          ST_CLAMPING: begin
            if (!on_ladder) begin
              state_d = on_floor ? ST_STANDING : ST_FLYING;
              vy_d    = '0;
            end else if (btn_up ^ btn_down) begin
              y_d = clamp_y(y_climb);
            end
          end

          ST_DYING: begin
            if (cnt_q == CNT_W'(DIE_TICKS - 1)) begin
              state_d   = ST_INITIAL;
              x_d       = 10'(START_X);
              y_d       = 9'(START_Y);
              vy_d      = '0;
              cnt_d     = '0;
              respawn_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end

          default: state_d = ST_INITIAL;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INITIAL;
      x_q       <= 10'(START_X);
      y_q       <= 9'(START_Y);
      vy_q      <= '0;
      cnt_q     <= '0;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vy_q      <= vy_d;
      cnt_q     <= cnt_d;
      respawn_q <= respawn_d;
    end
  end

  assign posX    = x_q;
  assign posY    = y_q;
  assign state   = state_q;
  assign respawn = respawn_q;

endmodule

// File: tb/tb_mario_motion.sv
// Scoreboard bench for mario_motion: expected outputs are queued as each
// cycle is driven and compared one cycle later, just after the clock edge.
module tb_mario_motion;

  localparam int S_INIT  = 0;
  localparam int S_FLY   = 1;
  localparam int S_JUMP  = 2;
  localparam int S_WALK  = 3;
  localparam int S_STAND = 4;
  localparam int S_DIE   = 5;
  localparam int S_CLAMP = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_jump = 1'b0;
  logic       on_floor = 1'b1, on_ladder = 1'b0, hit = 1'b0;
  logic [9:0] posX;
  logic [8:0] posY;
  logic [2:0] state;
  logic       respawn;

  always #5 clk = ~clk;

  mario_motion dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
    .btn_down(btn_down), .btn_jump(btn_jump),
    .on_floor(on_floor), .on_ladder(on_ladder), .hit(hit),
    .posX(posX), .posY(posY), .state(state), .respawn(respawn)
  );

  typedef struct {
    string tag;
    int    x;
    int    y;
    int    st;
    int    rsp;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   failures  = 0;

  // Vertical arc for a 12 px/tick jump with gravity 1 and fall cap 8 from y=390.
  int jump_y[12] = '{378, 367, 357, 348, 340, 333, 327, 322, 318, 315, 313, 312};
  int fall_y[15] = '{312, 313, 315, 318, 322, 327, 333, 340, 348, 356, 364, 372, 380, 388, 390};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic expect_out(input string tag, input int x, input int y, input int st, input int rsp);
    exp_t e;
    e.tag = tag; e.x = x; e.y = y; e.st = st; e.rsp = rsp;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".x"},       32'(posX),    32'(e.x));
      check({e.tag, ".y"},       32'(posY),    32'(e.y));
      check({e.tag, ".state"},   32'(state),   32'(e.st));
      check({e.tag, ".respawn"}, 32'(respawn), 32'(e.rsp));
    end
  endtask

  task automatic tick_and_check(input string tag, input int x, input int y, input int st, input int rsp);
    @(negedge clk);
    tick = 1'b1;
    expect_out(tag, x, y, st, rsp);
    @(posedge clk);
    #1;
    tick = 1'b0;
    compare_out();
  endtask

  task automatic idle_and_check(input string tag, input int x, input int y, input int st);
    @(negedge clk);
    expect_out(tag, x, y, st, 0);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    // Reset held across the first edge, with a tick pending at release.
    tick = 1'b1;
    #12;
    expect_out("reset", 80, 390, S_INIT, 0);
    compare_out();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_out("release_tick", 80, 390, S_INIT, 0);
    compare_out();
    tick = 1'b0;

    tick_and_check("init", 80, 390, S_STAND, 0);

    btn_right = 1'b1;
    tick_and_check("walk_r1", 82, 390, S_WALK, 0);
    tick_and_check("walk_r2", 84, 390, S_WALK, 0);

    // Asynchronous reset mid-walk, checked before any further clock edge.
    #3;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 80, 390, S_INIT, 0);
    compare_out();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    tick_and_check("reinit", 80, 390, S_STAND, 0);
    tick_and_check("walk_r3", 82, 390, S_WALK, 0);
    tick_and_check("walk_r4", 84, 390, S_WALK, 0);
    btn_right = 1'b0;
    tick_and_check("stop_84", 84, 390, S_STAND, 0);

    btn_left = 1'b1;
    tick_and_check("left_82", 82, 390, S_WALK, 0);
    tick_and_check("left_80", 80, 390, S_WALK, 0);
    tick_and_check("left_clamp", 80, 390, S_WALK, 0);
    btn_left = 1'b0;
    tick_and_check("left_stop", 80, 390, S_STAND, 0);

    // Inputs wiggled only on non-tick cycles must leave every output alone.
    for (int i = 0; i < 6; i++) begin
      btn_left  = i[0];
      btn_right = ~i[0];
      btn_jump  = i[1];
      hit       = (i == 3);
      idle_and_check($sformatf("gate%0d", i), 80, 390, S_STAND);
    end
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0; hit = 1'b0;

    // Jump arc; landing happens on the 28th tick counting the jump tick itself.
    btn_jump = 1'b1;
    tick_and_check("jump", 80, 390, S_JUMP, 0);
    btn_jump = 1'b0;
    on_floor = 1'b0;
    for (int k = 0; k < 12; k++)
      tick_and_check($sformatf("rise%0d", k), 80, jump_y[k], (k == 11) ? S_FLY : S_JUMP, 0);
    for (int k = 0; k < 15; k++)
      tick_and_check($sformatf("fall%0d", k), 80, fall_y[k], (k == 14) ? S_STAND : S_FLY, 0);
    on_floor = 1'b1;

    on_ladder = 1'b1;
    btn_up    = 1'b1;
    tick_and_check("ladder_in", 80, 390, S_CLAMP, 0);
    tick_and_check("climb1", 80, 388, S_CLAMP, 0);
    tick_and_check("climb2", 80, 386, S_CLAMP, 0);
    btn_up    = 1'b0;
    on_ladder = 1'b0;
    on_floor  = 1'b0;
    tick_and_check("ladder_off", 80, 386, S_FLY, 0);
    tick_and_check("drift", 80, 386, S_FLY, 0);
    on_floor = 1'b1;
    tick_and_check("floor_land", 80, 387, S_STAND, 0);

    btn_right = 1'b1;
    tick_and_check("walk_pre_hit", 82, 387, S_WALK, 0);
    btn_right = 1'b0;
    hit = 1'b1;
    tick_and_check("hit", 82, 387, S_DIE, 0);
    for (int k = 1; k <= 60; k++) begin
      hit = (k == 10);
      if (k < 60) tick_and_check($sformatf("die%0d", k), 82, 387, S_DIE, 0);
      else        tick_and_check("die_end", 80, 390, S_INIT, 1);
    end
    hit = 1'b0;
    idle_and_check("respawn_drop", 80, 390, S_INIT);

    hit = 1'b1;
    tick_and_check("init_ignores_hit", 80, 390, S_STAND, 0);
    hit = 1'b0;

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
